// File: rtl/param_cfg_sequencer.sv
// param_cfg_sequencer
//
// Replays a host-loaded table of (target, parameter index, value) entries
// over a valid/ready configuration bus. All targets are held in 'hold' from
// reset and from every accepted start until the whole table has been applied.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   tbl_we/addr/target/...   table write port, usable in any state
//   num_entries              valid entry count, sampled with start
//   start                    one-cycle replay request, ignored unless idle
//   cfg_valid/target/index/value, cfg_ready   configuration bus
//   hold                     per-target hold-in-configuration
//   busy, done               replay in progress / one-cycle completion pulse
//   bad_target               sticky: an entry named a nonexistent target
//   timeout_err              sticky ack timeout
//
// Build option: define PARAM_CFG_TIMEOUT_EN to abandon a beat that is not
// accepted within TIMEOUT_CYCLES cycles. Without it timeout_err is tied 0
// and the bus waits indefinitely.

module param_cfg_sequencer #(
    parameter int NUM_TARGETS    = 4,
    parameter int NUM_ENTRIES    = 8,
    parameter int IDX_W          = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tbl_we,
    input  logic [$clog2(NUM_ENTRIES)-1:0]   tbl_addr,
    input  logic [$clog2(NUM_TARGETS):0]     tbl_target,
    input  logic [IDX_W-1:0]                 tbl_index,
    input  logic [DATA_W-1:0]                tbl_value,
    input  logic [$clog2(NUM_ENTRIES):0]     num_entries,
    input  logic                             start,
    output logic                             cfg_valid,
    output logic [$clog2(NUM_TARGETS)-1:0]   cfg_target,
    output logic [IDX_W-1:0]                 cfg_index,
    output logic [DATA_W-1:0]                cfg_value,
    input  logic                             cfg_ready,
    output logic [NUM_TARGETS-1:0]           hold,
    output logic                             busy,
    output logic                             done,
    output logic                             bad_target,
    output logic                             timeout_err
);

    // state   | meaning
    // --------+-----------------------------------------------------------
    // S_IDLE  | waiting for start; hold keeps its last value
    // S_FETCH | latch table[ptr] into the beat registers, or skip a bad entry
    // S_ISSUE | cfg_valid high until the target accepts the beat
    // S_DONE  | one-cycle done pulse; hold already released

    localparam int AW = $clog2(NUM_ENTRIES);
    localparam int TW = $clog2(NUM_TARGETS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [TW:0]        tbl_tgt_q [NUM_ENTRIES];
    logic [IDX_W-1:0]   tbl_idx_q [NUM_ENTRIES];
    logic [DATA_W-1:0]  tbl_val_q [NUM_ENTRIES];

    logic [AW-1:0]      ptr;
    logic [AW:0]        cnt;
    logic [AW:0]        num_clamped;

    logic               start_ok;
    logic               fetch_skip;
    logic               ent_bad;
    logic               last_entry;
    logic               xfer;
    logic               tmo_zero;

    assign num_clamped = (num_entries > (AW+1)'(NUM_ENTRIES)) ? (AW+1)'(NUM_ENTRIES) : num_entries;
    assign ent_bad     = (tbl_tgt_q[ptr] >= (TW+1)'(NUM_TARGETS));
    assign last_entry  = (((AW+1)'(ptr) + (AW+1)'(1)) == cnt);
    assign xfer        = (state == S_ISSUE) && cfg_ready;

    assign cfg_valid   = (state == S_ISSUE);
    assign busy        = (state == S_FETCH) || (state == S_ISSUE);
    assign done        = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        start_ok   = 1'b0;
        fetch_skip = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_nx = (num_entries == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (ent_bad) begin
                    fetch_skip = 1'b1;
                    state_nx   = last_entry ? S_DONE : S_FETCH;
                end else begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cfg_ready)     state_nx = last_entry ? S_DONE : S_FETCH;
                else if (tmo_zero) state_nx = S_IDLE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_tgt_q[i] <= '0;
                tbl_idx_q[i] <= '0;
                tbl_val_q[i] <= '0;
            end
            ptr        <= '0;
            cnt        <= '0;
            cfg_target <= '0;
            cfg_index  <= '0;
            cfg_value  <= '0;
            hold       <= '1;
            bad_target <= 1'b0;
        end else begin
            if (tbl_we) begin
                tbl_tgt_q[tbl_addr] <= tbl_target;
                tbl_idx_q[tbl_addr] <= tbl_index;
                tbl_val_q[tbl_addr] <= tbl_value;
            end
            if (start_ok) begin
                ptr        <= '0;
                cnt        <= num_clamped;
                bad_target <= 1'b0;
                hold       <= '1;
            end
            // Beat fields are copied out of the table so a rewrite of the
            // entry in flight cannot disturb the bus until the next replay.
            if (state == S_FETCH && !ent_bad) begin
                cfg_target <= tbl_tgt_q[ptr][TW-1:0];
                cfg_index  <= tbl_idx_q[ptr];
                cfg_value  <= tbl_val_q[ptr];
            end
            if (fetch_skip) begin
                bad_target <= 1'b1;
                ptr        <= ptr + AW'(1);
            end
            if (xfer) ptr <= ptr + AW'(1);
            // Cleared on entry to DONE so hold falls together with done.
            if (state_nx == S_DONE) hold <= '0;
        end
    end

`ifdef PARAM_CFG_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_err_q;

    // Down-counter reloaded while fetching; reaching zero on the last
    // un-accepted ISSUE cycle abandons the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (state == S_FETCH)
                tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
            else if (state == S_ISSUE && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TMO_W'(1);

            if (start_ok)
                tmo_err_q <= 1'b0;
            else if (state == S_ISSUE && !cfg_ready && tmo_zero)
                tmo_err_q <= 1'b1;
        end
    end

    assign tmo_zero    = (tmo_cnt == '0);
    assign timeout_err = tmo_err_q;
`else
    assign tmo_zero    = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_cfg_sequencer.sv
module tb_param_cfg_sequencer;

    localparam int NT  = 4;
    localparam int NE  = 8;
    localparam int IW  = 4;
    localparam int DW  = 32;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tbl_we = 1'b0;
    logic [2:0]    tbl_addr = '0;
    logic [2:0]    tbl_target = '0;
    logic [IW-1:0] tbl_index = '0;
    logic [DW-1:0] tbl_value = '0;
    logic [3:0]    num_entries = '0;
    logic          start = 1'b0;
    logic          cfg_valid;
    logic [1:0]    cfg_target;
    logic [IW-1:0] cfg_index;
    logic [DW-1:0] cfg_value;
    logic          cfg_ready = 1'b0;
    logic [NT-1:0] hold;
    logic          busy;
    logic          done;
    logic          bad_target;
    logic          timeout_err;

    always #5 clk = ~clk;

    param_cfg_sequencer #(
        .NUM_TARGETS   (NT),
        .NUM_ENTRIES   (NE),
        .IDX_W         (IW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_target (tbl_target),
        .tbl_index  (tbl_index),
        .tbl_value  (tbl_value),
        .num_entries(num_entries),
        .start      (start),
        .cfg_valid  (cfg_valid),
        .cfg_target (cfg_target),
        .cfg_index  (cfg_index),
        .cfg_value  (cfg_value),
        .cfg_ready  (cfg_ready),
        .hold       (hold),
        .busy       (busy),
        .done       (done),
        .bad_target (bad_target),
        .timeout_err(timeout_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference copy of the table as the host believes it to be.
    int          m_t [NE];
    int          m_i [NE];
    logic [31:0] m_v [NE];

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic wr(input int a, input int t, input int i, input logic [31:0] v);
        tbl_we     = 1'b1;
        tbl_addr   = 3'(a);
        tbl_target = 3'(t);
        tbl_index  = 4'(i);
        tbl_value  = v;
        m_t[a] = t; m_i[a] = i; m_v[a] = v;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic load_basic();
        wr(0, 0, 0, 32);
        wr(1, 0, 1, 33);
        wr(2, 1, 0, 15);
    endtask

    // One replay. Expected beats are the in-range entries among the first
    // min(n, NE) in table order; each costs a fetch cycle plus one issue
    // cycle per offered-but-refused cycle, skipped entries cost one cycle.
    task automatic run(input string tag, input int n, input int stall_beat,
                       input int stall_len, input bit rnd, input int lit_done);
        int neff, nbad, exp_c, c, done_c, beats, in_beat, stalls;
        int hold_bad, busy_bad, stab_bad, streak, e;
        logic [NT-1:0] hold_at_done;
        logic          badt_at_done;
        logic [1:0]    h_t;
        logic [IW-1:0] h_i;
        logic [DW-1:0] h_v;
        int          q_e [$];
        int          s_t [$];
        int          s_i [$];
        logic [31:0] s_v [$];

        neff = (n > NE) ? NE : n;
        nbad = 0;
        for (int k = 0; k < neff; k++) begin
            if (m_t[k] >= NT) nbad++;
            else begin
                q_e.push_back(k);
                s_t.push_back(m_t[k]);
                s_i.push_back(m_i[k]);
                s_v.push_back(m_v[k]);
            end
        end

        start = 1'b1;
        num_entries = 4'(n);
        c = 0; done_c = -1; beats = 0; in_beat = 0; stalls = 0;
        hold_bad = 0; busy_bad = 0; stab_bad = 0; streak = 0;
        hold_at_done = '1; badt_at_done = 1'b0;
        h_t = '0; h_i = '0; h_v = '0;

        while (done_c < 0 && c < 300) begin
            @(negedge clk);
            c++;
            start  = 1'b0;
            tbl_we = 1'b0;
            if (done) begin
                done_c = c;
                hold_at_done = hold;
                badt_at_done = bad_target;
            end else begin
                if (hold !== '1) hold_bad++;
                if (busy !== 1'b1) busy_bad++;
            end
            if (cfg_valid) begin
                if (in_beat == 0) begin
                    if (beats < s_t.size()) begin
                        chk({tag, ":target"}, cfg_target, s_t[beats]);
                        chk({tag, ":index"},  cfg_index,  s_i[beats]);
                        chk({tag, ":value"},  cfg_value,  s_v[beats]);
                    end else begin
                        chk({tag, ":extra_beat"}, beats, s_t.size());
                    end
                    h_t = cfg_target; h_i = cfg_index; h_v = cfg_value;
                end else if (cfg_target !== h_t || cfg_index !== h_i || cfg_value !== h_v) begin
                    stab_bad++;
                end
                if (rnd) cfg_ready = (streak >= 4) || ($urandom_range(0, 2) != 0);
                else     cfg_ready = !(beats == stall_beat && in_beat < stall_len);
                if (rnd && beats < q_e.size() && $urandom_range(0, 3) == 0) begin
                    // Rewrite the entry on the bus; only later replays may see it.
                    e = q_e[beats];
                    m_t[e] = $urandom_range(0, 5);
                    m_i[e] = $urandom_range(0, 15);
                    m_v[e] = $urandom;
                    tbl_we     = 1'b1;
                    tbl_addr   = 3'(e);
                    tbl_target = 3'(m_t[e]);
                    tbl_index  = 4'(m_i[e]);
                    tbl_value  = m_v[e];
                end
                if (cfg_ready) begin beats++; in_beat = 0; streak = 0; end
                else begin stalls++; in_beat++; streak++; end
            end else begin
                cfg_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
        end

        exp_c = (neff == 0) ? 1 : 1 + 2 * s_t.size() + nbad + stalls;
        chk({tag, ":done_cycle"}, done_c, exp_c);
        if (lit_done >= 0) chk({tag, ":done_cycle_abs"}, done_c, lit_done);
        chk({tag, ":beats"}, beats, s_t.size());
        chk({tag, ":hold_before_done"}, hold_bad, 0);
        chk({tag, ":busy_before_done"}, busy_bad, 0);
        chk({tag, ":beat_stable"}, stab_bad, 0);
        chk({tag, ":hold_at_done"}, hold_at_done, 0);
        chk({tag, ":bad_target"}, badt_at_done, (nbad > 0) ? 1 : 0);

        @(negedge clk);
        tbl_we = 1'b0;
        cfg_ready = 1'b0;
        chk({tag, ":done_pulse_len"}, done, 0);
        chk({tag, ":idle_after"}, {busy, cfg_valid}, 0);
        chk({tag, ":hold_after"}, hold, 0);
    endtask

    initial begin
        int c, vcount, tmo_c, saw_done;

        for (int k = 0; k < NE; k++) begin m_t[k] = 0; m_i[k] = 0; m_v[k] = 0; end

        repeat (3) @(negedge clk);
        chk("rst:cfg_valid",   cfg_valid,   0);
        chk("rst:cfg_fields",  {cfg_target, cfg_index, cfg_value}, 0);
        chk("rst:hold",        hold,        4'hF);
        chk("rst:busy",        busy,        0);
        chk("rst:done",        done,        0);
        chk("rst:bad_target",  bad_target,  0);
        chk("rst:timeout_err", timeout_err, 0);
        rst = 1'b0;
        @(negedge clk);

        load_basic();
        run("basic", 3, -1, 0, 1'b0, 7);
        run("stall", 3, 1, 5, 1'b0, 12);

        wr(1, NT, 2, 77);
        run("bad_tgt", 3, -1, 0, 1'b0, 6);

        run("zero", 0, -1, 0, 1'b0, 1);

        // Reset in the middle of the second beat.
        load_basic();
        start = 1'b1;
        num_entries = 4'd3;
        cfg_ready = 1'b1;
        vcount = 0; c = 0;
        while (vcount < 2 && c < 50) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (cfg_valid) vcount++;
        end
        chk("rst_mid:reached_beat2", vcount, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid:cfg_valid",  cfg_valid, 0);
        chk("rst_mid:cfg_fields", {cfg_target, cfg_index, cfg_value}, 0);
        chk("rst_mid:hold",       hold, 4'hF);
        chk("rst_mid:busy_done",  {busy, done, bad_target, timeout_err}, 0);
        rst = 1'b0;
        cfg_ready = 1'b0;
        for (int k = 0; k < NE; k++) begin m_t[k] = 0; m_i[k] = 0; m_v[k] = 0; end
        @(negedge clk);
        run("rst_cleared_tbl", 3, -1, 0, 1'b0, 7);
        load_basic();
        run("rst_reload", 3, -1, 0, 1'b0, 7);

        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < NE; k++)
                wr(k, $urandom_range(0, 5), $urandom_range(0, 15), $urandom);
            run($sformatf("rand%0d", it), $urandom_range(0, 12), -1, 0, 1'b1, -1);
        end

`ifdef PARAM_CFG_TIMEOUT_EN
        wr(0, 2, 3, 99);
        start = 1'b1;
        num_entries = 4'd1;
        cfg_ready = 1'b0;
        c = 0; tmo_c = -1; saw_done = 0;
        while (tmo_c < 0 && c < 60) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (done) saw_done = 1;
            if (timeout_err) tmo_c = c;
        end
        chk("tmo:cycle",     tmo_c, 2 + TMO);
        chk("tmo:cfg_valid", cfg_valid, 0);
        chk("tmo:hold",      hold, 4'hF);
        chk("tmo:no_done",   saw_done, 0);
`else
        chk("tmo:tied_off", timeout_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
